subckt_test_sched: RTL and testbench

Sequencer that shares one pseudo-random stimulus bus among `N_DUT` instances of a flop-based benchmark subcircuit. For each instance in turn it applies a configurable number of LFSR vectors, holds each vector for a fixed settle time, and compacts the selected instance's output into a 16-bit MISR signature. The signature is handed to the trojan-detection compare logic over a valid/ready handshake. The block sits between the test-control register block and the bank of subcircuit instances.

---
 rtl/subckt_test_sched_if.sv | 35 +++
 rtl/subckt_test_sched.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_subckt_test_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/subckt_test_sched_if.sv
// -----------------------------------------------------------------------------
// subckt_test_sched_if
// Bundle between the test scheduler and the subcircuit bank / signature
// consumer.
//   stim      : shared pseudo-random stimulus driven to every instance
//   dut_sel   : index of the instance whose response is being compacted
//   dut_resp  : one response bit per instance
//   sig       : MISR signature of the selected instance
//   sig_valid : signature valid (handshake with sig_ready)
//   sig_ready : consumer accepts the signature
// Modports: master = scheduler side, slave = bank/consumer side.
// -----------------------------------------------------------------------------
interface subckt_test_sched_if #(
   parameter int N_IN  = 6,
   parameter int N_DUT = 4
);
   localparam int SEL_W = $clog2(N_DUT);

   logic [N_IN-1:0]  stim;
   logic [SEL_W-1:0] dut_sel;
   logic [N_DUT-1:0] dut_resp;
   logic [15:0]      sig;
   logic             sig_valid;
   logic             sig_ready;

   modport master (
      output stim, dut_sel, sig, sig_valid,
      input  dut_resp, sig_ready
   );

   modport slave (
      input  stim, dut_sel, sig, sig_valid,
      output dut_resp, sig_ready
   );
endinterface

// File: rtl/subckt_test_sched.sv
// -----------------------------------------------------------------------------
// subckt_test_sched
// Shares one LFSR stimulus bus among N_DUT subcircuit instances. For each
// instance in turn it applies vec_count vectors, holds each for SETTLE cycles,
// compacts the selected instance's response into a 16-bit MISR and reports the
// signature over a valid/ready handshake.
//
// Ports:
//   I1294_clk  : clock, rising edge
//   I1301_rst  : asynchronous active-high reset
//   start      : begin a run (sampled in IDLE only)
//   abort      : terminate the run from any state
//   vec_count  : vectors per instance, latched on start
//   seed       : LFSR seed, latched on start (0 selects 16'hACE1)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the last instance is reported
//   bus        : subckt_test_sched_if.master (stim/dut_sel/dut_resp/sig/...)
//
// Optional feature macro: SUBCKT_TEST_GOLDEN_CMP_EN
//   adds input golden (16 bits per instance) and sticky output mismatch.
// -----------------------------------------------------------------------------
module subckt_test_sched #(
   parameter int N_IN   = 6,
   parameter int N_DUT  = 4,
   parameter int SETTLE = 4
) (
   input  logic        I1294_clk,
   input  logic        I1301_rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] vec_count,
   input  logic [15:0] seed,
   output logic        busy,
   output logic        done,
   subckt_test_sched_if.master bus
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
   ,
   input  logic [16*N_DUT-1:0] golden,
   output logic                mismatch
`endif
);

   localparam int               SEL_W        = $clog2(N_DUT);
   localparam int               SIG_W        = 16;
   localparam logic [15:0]      DEFAULT_SEED = 16'hACE1;
   localparam logic [3:0]       SETTLE_LOAD  = 4'(SETTLE);
   localparam logic [SEL_W-1:0] LAST_SEL     = SEL_W'(N_DUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_REPORT = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t state_r, state_d;

   logic [15:0]      lfsr_r, lfsr_d;
   logic [15:0]      misr_r, misr_d;
   logic [15:0]      vcnt_r, vcnt_d;
   logic [15:0]      vlim_r, vlim_d;
   logic [15:0]      seed_r, seed_d;
   logic [3:0]       settle_r, settle_d;
   logic [SEL_W-1:0] sel_r, sel_d;
   logic [N_IN-1:0]  stim_r, stim_d;
   logic             busy_r, busy_d;
   logic             done_r, done_d;
   logic             valid_r, valid_d;

   logic             start_ok_s;
   logic             settle_end_s;
   logic             last_vec_s;
   logic             last_dut_s;
   logic             accept_s;
   logic             resp_s;
   logic [15:0]      seed_eff_s;

   // Shift register step shared by the LFSR and the MISR (taps 15,13,12,10).
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // MISR step: LFSR shift with the response bit folded into bit 0.
   function automatic logic [15:0] misr_step(input logic [15:0] m, input logic r);
      return lfsr_step(m) ^ {15'b0, r};
   endfunction

   assign start_ok_s   = start && (vec_count != 16'h0000);
   assign settle_end_s = (settle_r == 4'h1);
   assign last_vec_s   = ((vcnt_r + 16'h0001) == vlim_r);
   assign last_dut_s   = (sel_r == LAST_SEL);
   assign accept_s     = valid_r && bus.sig_ready;
   assign resp_s       = bus.dut_resp[sel_r];
   assign seed_eff_s   = (seed == 16'h0000) ? DEFAULT_SEED : seed;

`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
   logic        mism_r, mism_d;
   logic [15:0] golden_s;

   assign golden_s = golden[{sel_r, 4'b0000} +: SIG_W];
   assign mismatch = mism_r;
`endif

   // State register.
   always_ff @(posedge I1294_clk or posedge I1301_rst) begin
      if (I1301_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_d;
      end
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_d = state_r;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) state_d = ST_APPLY;
               else            state_d = ST_IDLE;
            end
            ST_APPLY: begin
               state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!settle_end_s)   state_d = ST_SETTLE;
               else if (last_vec_s) state_d = ST_REPORT;
               else                 state_d = ST_APPLY;
            end
            ST_REPORT: begin
               if (!accept_s)       state_d = ST_REPORT;
               else if (last_dut_s) state_d = ST_DONE;
               else                 state_d = ST_APPLY;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Datapath next values and the output values seen in the next state.
   always_comb begin
      lfsr_d   = lfsr_r;
      misr_d   = misr_r;
      vcnt_d   = vcnt_r;
      vlim_d   = vlim_r;
      seed_d   = seed_r;
      settle_d = settle_r;
      sel_d    = sel_r;
      stim_d   = stim_r;
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
      mism_d   = mism_r;
`endif
      if (abort) begin
         lfsr_d   = 16'h0000;
         misr_d   = 16'h0000;
         vcnt_d   = 16'h0000;
         settle_d = 4'h0;
         sel_d    = {SEL_W{1'b0}};
         stim_d   = {N_IN{1'b0}};
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
         mism_d   = 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  seed_d = seed_eff_s;
                  vlim_d = vec_count;
                  lfsr_d = seed_eff_s;
                  misr_d = 16'h0000;
                  vcnt_d = 16'h0000;
                  sel_d  = {SEL_W{1'b0}};
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
                  mism_d = 1'b0;
`endif
               end else begin
                  seed_d = seed_r;
               end
            end
            ST_APPLY: begin
               settle_d = SETTLE_LOAD;
            end
            ST_SETTLE: begin
               settle_d = settle_r - 4'h1;
               // Last settle cycle: compact the response and step to the next vector.
               if (settle_end_s) begin
                  misr_d = misr_step(misr_r, resp_s);
                  lfsr_d = lfsr_step(lfsr_r);
                  if (last_vec_s) vcnt_d = vcnt_r;
                  else            vcnt_d = vcnt_r + 16'h0001;
               end else begin
                  misr_d = misr_r;
               end
            end
            ST_REPORT: begin
               if (accept_s) begin
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
                  if (misr_r != golden_s) mism_d = 1'b1;
                  else                    mism_d = mism_r;
`endif
                  // Next instance restarts from the same vector sequence.
                  if (!last_dut_s) begin
                     sel_d  = sel_r + SEL_W'(1);
                     misr_d = 16'h0000;
                     vcnt_d = 16'h0000;
                     lfsr_d = seed_r;
                  end else begin
                     sel_d = sel_r;
                  end
               end else begin
                  sel_d = sel_r;
               end
            end
            ST_DONE: begin
               sel_d = sel_r;
            end
            default: begin
               sel_d = sel_r;
            end
         endcase
         // stim only moves when a vector is applied, so it stays put through
         // SETTLE and REPORT even though the LFSR has already advanced.
         if (state_d == ST_APPLY) stim_d = lfsr_d[N_IN-1:0];
         else                     stim_d = stim_r;
      end
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
      valid_d = (state_d == ST_REPORT);
   end

   // Datapath and output registers.
   always_ff @(posedge I1294_clk or posedge I1301_rst) begin
      if (I1301_rst) begin
         lfsr_r   <= 16'h0000;
         misr_r   <= 16'h0000;
         vcnt_r   <= 16'h0000;
         vlim_r   <= 16'h0000;
         seed_r   <= 16'h0000;
         settle_r <= 4'h0;
         sel_r    <= {SEL_W{1'b0}};
         stim_r   <= {N_IN{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         valid_r  <= 1'b0;
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
         mism_r   <= 1'b0;
`endif
      end else begin
         lfsr_r   <= lfsr_d;
         misr_r   <= misr_d;
         vcnt_r   <= vcnt_d;
         vlim_r   <= vlim_d;
         seed_r   <= seed_d;
         settle_r <= settle_d;
         sel_r    <= sel_d;
         stim_r   <= stim_d;
         busy_r   <= busy_d;
         done_r   <= done_d;
         valid_r  <= valid_d;
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
         mism_r   <= mism_d;
`endif
      end
   end

   assign bus.stim      = stim_r;
   assign bus.dut_sel   = sel_r;
   assign bus.sig       = misr_r;
   assign bus.sig_valid = valid_r;
   assign busy          = busy_r;
   assign done          = done_r;

endmodule

// File: tb/tb_subckt_test_sched.sv
// -----------------------------------------------------------------------------
// tb_subckt_test_sched
// Directed and randomized stimulus for subckt_test_sched. A timeline model
// (position within the current instance's vector window) predicts busy, done,
// sig_valid, stim, dut_sel, sig and mismatch; one negedge process compares the
// DUT with it every cycle. Directed runs add literal expectations.
// -----------------------------------------------------------------------------
module tb_subckt_test_sched;
   localparam int N_IN  = 6;
   localparam int N_DUT = 4;
   localparam int S     = 4;
   localparam int VW    = S + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] vec_count = 16'h0000;
   logic [15:0] seed = 16'h0000;
   logic        busy;
   logic        done;
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
   logic [16*N_DUT-1:0] golden = '0;
   logic                mismatch;
`endif

   int checks = 0;
   int errors = 0;

   subckt_test_sched_if #(.N_IN(N_IN), .N_DUT(N_DUT)) bus_if ();

   subckt_test_sched #(.N_IN(N_IN), .N_DUT(N_DUT), .SETTLE(S)) dut (
      .I1294_clk (clk),
      .I1301_rst (rst),
      .start     (start),
      .abort     (abort),
      .vec_count (vec_count),
      .seed      (seed),
      .busy      (busy),
      .done      (done),
      .bus       (bus_if)
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
      ,
      .golden    (golden),
      .mismatch  (mismatch)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [15:0] step16(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [N_IN-1:0] stim_of(input logic [15:0] s, input int k);
      logic [15:0] v;
      v = s;
      for (int i = 0; i < k; i++) v = step16(v);
      return v[N_IN-1:0];
   endfunction

   bit              m_act, m_dcyc, m_clr, m_mism;
   int              m_pos, m_inst, m_vlim;
   logic [15:0]     m_seed, m_sig;
   logic [N_IN-1:0] m_stim;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act <= 1'b0; m_dcyc <= 1'b0; m_clr <= 1'b1; m_mism <= 1'b0;
         m_pos <= 0; m_inst <= 0; m_vlim <= 0;
         m_seed <= 16'h0000; m_sig <= 16'h0000; m_stim <= '0;
      end else if (abort) begin
         m_act <= 1'b0; m_dcyc <= 1'b0; m_clr <= 1'b1; m_mism <= 1'b0;
         m_inst <= 0; m_sig <= 16'h0000; m_stim <= '0;
      end else if (m_dcyc) begin
         m_dcyc <= 1'b0;
         m_act  <= 1'b0;
      end else if (!m_act) begin
         if (start && vec_count != 16'h0000) begin
            m_act  <= 1'b1;
            m_clr  <= 1'b0;
            m_mism <= 1'b0;
            m_vlim <= int'(vec_count);
            m_seed <= (seed == 16'h0000) ? 16'hACE1 : seed;
            m_stim <= stim_of((seed == 16'h0000) ? 16'hACE1 : seed, 0);
            m_inst <= 0;
            m_pos  <= 0;
            m_sig  <= 16'h0000;
         end
      end else if (m_pos < m_vlim * VW) begin
         if (m_pos % VW == S) m_sig <= step16(m_sig) ^ {15'b0, bus_if.dut_resp[m_inst]};
         m_pos <= m_pos + 1;
         if (((m_pos + 1) % VW == 0) && (m_pos + 1 < m_vlim * VW))
            m_stim <= stim_of(m_seed, (m_pos + 1) / VW);
      end else if (bus_if.sig_ready) begin
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
         if (m_sig != golden[m_inst*16 +: 16]) m_mism <= 1'b1;
`endif
         if (m_inst == N_DUT - 1) begin
            m_dcyc <= 1'b1;
         end else begin
            m_inst <= m_inst + 1;
            m_pos  <= 0;
            m_sig  <= 16'h0000;
            m_stim <= stim_of(m_seed, 0);
         end
      end
   end

   // Compare process: DUT against the model every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", 32'(busy), 32'(m_act));
         chk("done", 32'(done), 32'(m_dcyc));
         chk("sig_valid", 32'(bus_if.sig_valid), 32'(m_act && !m_dcyc && m_pos == m_vlim * VW));
         chk("stim", 32'(bus_if.stim), 32'(m_stim));
         if (m_act && !m_dcyc) chk("dut_sel", 32'(bus_if.dut_sel), m_inst);
         if ((m_act && !m_dcyc && m_pos == m_vlim * VW) || m_clr)
            chk("sig", 32'(bus_if.sig), 32'(m_sig));
`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
         chk("mismatch", 32'(mismatch), 32'(m_mism));
`endif
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic run_check(input string tag, input logic [15:0] sd, input logic [15:0] vc,
                            input logic [N_DUT-1:0] resp, input bit chk_sig,
                            input logic [15:0] exp_sig, input int exp_lat,
                            input logic [N_IN-1:0] exp_st0, input logic [N_IN-1:0] exp_st1);
      int n, lat, nvalid, last_v, done_n;
      seed = sd; vec_count = vc; bus_if.dut_resp = resp; bus_if.sig_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
      chk({tag, " stim_first"}, 32'(bus_if.stim), 32'(exp_st0));
      n = 0; lat = -1; nvalid = 0; last_v = -1; done_n = -1;
      while (done_n < 0 && n < 400) begin
         if (n == VW) chk({tag, " stim_second"}, 32'(bus_if.stim), 32'(exp_st1));
         if (bus_if.sig_valid) begin
            if (lat < 0) lat = n;
            chk({tag, " sel_order"}, 32'(bus_if.dut_sel), nvalid);
            if (chk_sig) chk({tag, " sig"}, 32'(bus_if.sig), 32'(exp_sig));
            nvalid++;
            last_v = n;
         end
         if (done) done_n = n;
         step();
         n++;
      end
      chk({tag, " first_valid_latency"}, lat, exp_lat);
      chk({tag, " valid_count"}, nvalid, N_DUT);
      chk({tag, " done_after_last_accept"}, done_n, last_v + 1);
      chk({tag, " busy_low_after_done"}, 32'(busy), 32'd0);
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] hs;
      logic [1:0]  hsel;
      logic [N_IN-1:0] hst;
      int n;
      bit saw_done;

      bus_if.dut_resp = '0;
      bus_if.sig_ready = 1'b1;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;

      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset stim", 32'(bus_if.stim), 32'd0);
      chk("reset sig", 32'(bus_if.sig), 32'd0);
      chk("reset sig_valid", 32'(bus_if.sig_valid), 32'd0);
      chk("reset dut_sel", 32'(bus_if.dut_sel), 32'd0);
      step();

      run_check("A", 16'h0001, 16'd1, 4'h0, 1'b1, 16'h0000, 1 * VW, 6'h01, 6'h01);
      run_check("B", 16'h0001, 16'd2, 4'hF, 1'b1, 16'h0003, 2 * VW, 6'h01, 6'h02);
      run_check("C", 16'h0000, 16'd1, 4'h5, 1'b0, 16'h0000, 1 * VW, 6'h21, 6'h21);

      // start with vec_count = 0 is ignored
      vec_count = 16'd0; start = 1'b1;
      step();
      start = 1'b0;
      chk("zero_count busy", 32'(busy), 32'd0);
      step();
      chk("zero_count busy_later", 32'(busy), 32'd0);

      // sig_ready held low in REPORT
      seed = 16'h1234; vec_count = 16'd3; bus_if.sig_ready = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!bus_if.sig_valid && n < 200) begin
         bus_if.dut_resp = 4'($urandom);
         step();
         n++;
      end
      chk("hold reached_report", 32'(bus_if.sig_valid), 32'd1);
      hs = bus_if.sig; hsel = bus_if.dut_sel; hst = bus_if.stim;
      repeat (10) begin
         bus_if.dut_resp = 4'($urandom);
         step();
         chk("hold sig", 32'(bus_if.sig), 32'(hs));
         chk("hold dut_sel", 32'(bus_if.dut_sel), 32'(hsel));
         chk("hold stim", 32'(bus_if.stim), 32'(hst));
      end
      bus_if.sig_ready = 1'b1;
      n = 0;
      while (!done && n < 300) begin step(); n++; end
      chk("hold run_completes", 32'(done), 32'd1);
      step();

      // abort mid-SETTLE of instance 2
      seed = 16'h00A5; vec_count = 16'd2; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!(bus_if.dut_sel == 2'd2 && !bus_if.sig_valid) && n < 300) begin step(); n++; end
      chk("abort reached_inst2", 32'(bus_if.dut_sel), 32'd2);
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort stim", 32'(bus_if.stim), 32'd0);
      chk("abort sig", 32'(bus_if.sig), 32'd0);
      saw_done = 1'b0;
      repeat (6) begin
         if (done) saw_done = 1'b1;
         step();
      end
      chk("abort no_done", 32'(saw_done), 32'd0);
      run_check("E", 16'h00A5, 16'd1, 4'hA, 1'b0, 16'h0000, 1 * VW, 6'h25, 6'h25);

      // abort coincident with a REPORT accept
      seed = 16'h0007; vec_count = 16'd1; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while (!(bus_if.sig_valid && bus_if.dut_sel == 2'd1) && n < 300) begin step(); n++; end
      chk("abort_accept reached", 32'(bus_if.sig_valid), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_accept busy", 32'(busy), 32'd0);
      saw_done = 1'b0;
      repeat (20) begin
         if (done || bus_if.sig_valid) saw_done = 1'b1;
         step();
      end
      chk("abort_accept no_more_activity", 32'(saw_done), 32'd0);

`ifdef SUBCKT_TEST_GOLDEN_CMP_EN
      golden = '0;
      golden[31:16] = 16'h0001;
      run_check("F", 16'h0001, 16'd1, 4'h0, 1'b1, 16'h0000, 1 * VW, 6'h01, 6'h01);
      chk("golden mismatch_sticky", 32'(mismatch), 32'd1);
      golden = {$urandom, $urandom};
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus_if.dut_resp  = 4'($urandom);
         bus_if.sig_ready = ($urandom_range(0, 3) != 0);
         start            = ($urandom_range(0, 7) == 0);
         abort            = ($urandom_range(0, 149) == 0);
         vec_count        = 16'($urandom_range(0, 4));
         seed             = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         step();
      end
      start = 1'b0;
      abort = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
